// File: rtl/mult_scaler_array_pkg.sv
// ---------------------------------------------------------------------------
// mult_scaler_array_pkg
// Shared width defaults and types for the multi-lane scaler multiplier.
//   ADD_OUT_WIDTH         : signed accumulator lane width (adder-tree output)
//   SCALER_WIDTH          : signed per-lane scale factor width
//   MULT_SCALER_OUT_WIDTH : signed lane output width
//   SHIFT_WIDTH           : width of the runtime right-shift amount
//   SAT_CNT_W             : width of the saturation event counter
// ---------------------------------------------------------------------------
package mult_scaler_array_pkg;

    localparam int DEFAULT_CH            = 4;
    localparam int ADD_OUT_WIDTH         = 16;
    localparam int SCALER_WIDTH          = 8;
    localparam int MULT_SCALER_OUT_WIDTH = 16;
    localparam int SHIFT_WIDTH           = 5;
    localparam int SAT_CNT_W             = 32;

    // Output formatting mode carried alongside each beat.
    typedef enum logic {
        MODE_SLICE = 1'b0,
        MODE_ROUND = 1'b1
    } scale_mode_e;

endpackage

// File: rtl/mult_scaler_array_if.sv
// ---------------------------------------------------------------------------
// mult_scaler_array_if
// Valid/ready bus bundle for mult_scaler_array.
//   master : producer/consumer side (drives in_*, out_ready, cnt_clr)
//   slave  : the scaler array (drives in_ready, out_*, sat_flag, sat_count)
// Lane i of in_data/scale/out_data sits at [i*W +: W].
// ---------------------------------------------------------------------------
interface mult_scaler_array_if
    import mult_scaler_array_pkg::*;
#(
    parameter int CH      = DEFAULT_CH,
    parameter int IN_W    = ADD_OUT_WIDTH,
    parameter int SC_W    = SCALER_WIDTH,
    parameter int OUT_W   = MULT_SCALER_OUT_WIDTH,
    parameter int SHIFT_W = SHIFT_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [CH*IN_W-1:0]    in_data;
    logic [CH*SC_W-1:0]    scale;
    logic [SHIFT_W-1:0]    shift;
    logic                  mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [CH*OUT_W-1:0]   out_data;
    logic [CH-1:0]         sat_flag;
    logic                  cnt_clr;
    logic [SAT_CNT_W-1:0]  sat_count;

    modport master (
        output in_valid, in_data, scale, shift, mode, out_ready, cnt_clr,
        input  in_ready, out_valid, out_data, sat_flag, sat_count
    );

    modport slave (
        input  in_valid, in_data, scale, shift, mode, out_ready, cnt_clr,
        output in_ready, out_valid, out_data, sat_flag, sat_count
    );

endinterface

// File: rtl/mult_scaler_array_lane.sv
// ---------------------------------------------------------------------------
// scaler_lane
// One lane of the scaler array: stage 1 registers the full-width signed
// product with its mode and clamped shift; stage 2 formats it either as the
// legacy top slice or as round-half-up / arithmetic shift / saturate.
//   clk, rst  : clock, async active-high reset
//   load1_i   : capture a new product into stage 1
//   load2_i   : move stage 1 into the output register
//   a_i, b_i  : signed lane operand and scale factor
//   shift_i   : requested right shift (clamped to PW-1)
//   mode_i    : 0 = top slice, 1 = round/shift/saturate
//   data_o    : registered signed lane result
//   sat_o     : registered saturation flag for data_o
// ---------------------------------------------------------------------------
module scaler_lane
    import mult_scaler_array_pkg::*;
#(
    parameter int IN_W    = ADD_OUT_WIDTH,
    parameter int SC_W    = SCALER_WIDTH,
    parameter int OUT_W   = MULT_SCALER_OUT_WIDTH,
    parameter int SHIFT_W = SHIFT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load1_i,
    input  logic                     load2_i,
    input  logic signed [IN_W-1:0]   a_i,
    input  logic signed [SC_W-1:0]   b_i,
    input  logic [SHIFT_W-1:0]       shift_i,
    input  logic                     mode_i,
    output logic signed [OUT_W-1:0]  data_o,
    output logic                     sat_o
);

    localparam int PW = IN_W + SC_W;

    // Saturation bounds held at PW+1 bits so they compare directly with the
    // rounded value; the minimum is the bitwise complement of the maximum.
    localparam logic signed [PW:0] SAT_MAX = (PW+1)'((longint'(1) << (OUT_W-1)) - 1);
    localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;

    logic signed [PW-1:0]    prod_q, prod_d;
    scale_mode_e             mode_q;
    logic [SHIFT_W-1:0]      shift_q, shiftClamp;
    logic signed [PW:0]      prodExt, roundBias, biased, shifted;
    logic signed [OUT_W-1:0] data_q, data_d;
    logic                    sat_q, sat_d;

    // Stage-1 inputs: operands are sign-extended to PW before multiplying so
    // the product keeps every bit; shifts beyond PW-1 are clamped.
    always_comb begin
        prod_d     = PW'(a_i) * PW'(b_i);
        shiftClamp = (int'(shift_i) > PW - 1) ? SHIFT_W'(PW - 1) : shift_i;
    end

    // Stage-1 register: product plus the per-beat formatting controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            mode_q  <= MODE_SLICE;
            shift_q <= '0;
        end else if (load1_i) begin
            prod_q  <= prod_d;
            mode_q  <= scale_mode_e'(mode_i);
            shift_q <= shiftClamp;
        end
    end

    // Stage-2 formatting. The rounding add is done one bit wider than the
    // product so adding half an LSB can never wrap.
    always_comb begin
        prodExt   = (PW+1)'(prod_q);
        roundBias = (shift_q == '0) ? '0 : ((PW+1)'(1) << (shift_q - 1'b1));
        biased    = prodExt + roundBias;
        shifted   = biased >>> shift_q;
        data_d    = prod_q[PW-1 -: OUT_W];
        sat_d     = 1'b0;
        if (mode_q == MODE_ROUND) begin
            if (shifted > SAT_MAX) begin
                data_d = SAT_MAX[OUT_W-1:0];
                sat_d  = 1'b1;
            end else if (shifted < SAT_MIN) begin
                data_d = SAT_MIN[OUT_W-1:0];
                sat_d  = 1'b1;
            end else begin
                data_d = shifted[OUT_W-1:0];
            end
        end
    end

    // Output register: only loads when a stage-1 beat moves forward, so the
    // result stays put while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            sat_q  <= 1'b0;
        end else if (load2_i) begin
            data_q <= data_d;
            sat_q  <= sat_d;
        end
    end

    assign data_o = data_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/mult_scaler_array.sv
// ---------------------------------------------------------------------------
// mult_scaler_array
// CH-lane pipelined scaler multiplier with valid/ready flow control and a
// saturation event counter for calibration.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (discards in-flight beats)
//   bus  : slave side of mult_scaler_array_if
//          in_valid/in_ready/in_data/scale/shift/mode  : input beat
//          out_valid/out_ready/out_data/sat_flag       : output beat
//          cnt_clr/sat_count                           : saturation counter
// Latency is two cycles; a full two-stage pipeline keeps streaming at one
// beat per cycle as long as out_ready is high.
// ---------------------------------------------------------------------------
module mult_scaler_array
    import mult_scaler_array_pkg::*;
#(
    parameter int CH      = DEFAULT_CH,
    parameter int IN_W    = ADD_OUT_WIDTH,
    parameter int SC_W    = SCALER_WIDTH,
    parameter int OUT_W   = MULT_SCALER_OUT_WIDTH,
    parameter int SHIFT_W = SHIFT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    mult_scaler_array_if.slave bus
);

    logic                  valid1_q, valid2_q;
    logic                  en1, en2;
    logic                  load1, load2;
    logic                  outXfer;
    logic [CH*OUT_W-1:0]   laneData;
    logic [CH-1:0]         laneSat;
    logic [SAT_CNT_W-1:0]  satCount_q, satCount_d;

    // A stage may take new data when it is empty or when the stage after it
    // is moving; this chains back combinationally from out_ready.
    always_comb begin
        en2     = !valid2_q || bus.out_ready;
        en1     = !valid1_q || en2;
        load1   = en1 && bus.in_valid;
        load2   = en2 && valid1_q;
        outXfer = valid2_q && bus.out_ready;
    end

    assign bus.in_ready  = en1 && !rst;
    assign bus.out_valid = valid2_q;
    assign bus.out_data  = laneData;
    assign bus.sat_flag  = laneSat;
    assign bus.sat_count = satCount_q;

    // Stage valid bits follow the same enables as the lane data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
        end else begin
            if (en1) begin
                valid1_q <= bus.in_valid;
            end
            if (en2) begin
                valid2_q <= valid1_q;
            end
        end
    end

    // Count transferred beats with any lane saturated; clear wins over an
    // increment in the same cycle and the count sticks at all-ones.
    always_comb begin
        satCount_d = satCount_q;
        if (bus.cnt_clr) begin
            satCount_d = '0;
        end else if (outXfer && (|laneSat) && (satCount_q != '1)) begin
            satCount_d = satCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            satCount_q <= '0;
        end else begin
            satCount_q <= satCount_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : gLane
        scaler_lane #(
            .IN_W    (IN_W),
            .SC_W    (SC_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) uLane (
            .clk     (clk),
            .rst     (rst),
            .load1_i (load1),
            .load2_i (load2),
            .a_i     (bus.in_data[g*IN_W +: IN_W]),
            .b_i     (bus.scale[g*SC_W +: SC_W]),
            .shift_i (bus.shift),
            .mode_i  (bus.mode),
            .data_o  (laneData[g*OUT_W +: OUT_W]),
            .sat_o   (laneSat[g])
        );
    end

endmodule

// File: tb/tb_mult_scaler_array.sv
// ---------------------------------------------------------------------------
// tb_mult_scaler_array
// Self-checking bench for mult_scaler_array. Inputs are driven on the falling
// edge and outputs sampled 1 ns later; expected beats come from an
// arithmetic reference model pushed into a queue at each input transfer.
// ---------------------------------------------------------------------------
module tb_mult_scaler_array;
    import mult_scaler_array_pkg::*;

    localparam int CH      = 4;
    localparam int IN_W    = ADD_OUT_WIDTH;
    localparam int SC_W    = SCALER_WIDTH;
    localparam int OUT_W   = MULT_SCALER_OUT_WIDTH;
    localparam int SHIFT_W = SHIFT_WIDTH;
    localparam int PW      = IN_W + SC_W;

    typedef struct packed {
        logic [CH*OUT_W-1:0] data;
        logic [CH-1:0]       sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mult_scaler_array_if #(
        .CH(CH), .IN_W(IN_W), .SC_W(SC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
    ) bus ();

    mult_scaler_array #(
        .CH(CH), .IN_W(IN_W), .SC_W(SC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int                  errors = 0;
    int                  checks = 0;
    exp_t                expQ[$];
    exp_t                expOut;
    longint unsigned     modelCnt = 0;
    longint unsigned     expCnt;
    logic                obsValid, obsInReady;
    logic [CH*OUT_W-1:0] obsData;
    logic [CH-1:0]       obsSat;
    logic [31:0]         obsCount;
    bit                  inX, outX;

    // Reference: exact product, then floor-shift / round-half-up / clamp.
    function automatic exp_t refModel(input logic [CH*IN_W-1:0] d,
                                      input logic [CH*SC_W-1:0] sc,
                                      input int sh, input logic md);
        exp_t   e;
        longint a, b, p, r, s;
        longint maxV;
        longint minV;
        maxV = (longint'(1) << (OUT_W-1)) - 1;
        minV = -maxV - 1;
        e = '0;
        for (int i = 0; i < CH; i++) begin
            a = longint'($signed(d[i*IN_W +: IN_W]));
            b = longint'($signed(sc[i*SC_W +: SC_W]));
            p = a * b;
            if (!md) begin
                r = p >>> (PW - OUT_W);
            end else begin
                s = (sh > PW - 1) ? PW - 1 : sh;
                r = (s > 0) ? ((p + (longint'(1) << (s - 1))) >>> s) : p;
                if (r > maxV) begin
                    r = maxV;
                    e.sat[i] = 1'b1;
                end else if (r < minV) begin
                    r = minV;
                    e.sat[i] = 1'b1;
                end
            end
            e.data[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
        end
        return e;
    endfunction

    task automatic setLanes(input int a[CH], input int b[CH]);
        for (int i = 0; i < CH; i++) begin
            bus.in_data[i*IN_W +: IN_W] = IN_W'(a[i]);
            bus.scale[i*SC_W +: SC_W]   = SC_W'(b[i]);
        end
    endtask

    task automatic randomLanes();
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 5))
                0:       bus.in_data[i*IN_W +: IN_W] = {1'b0, {(IN_W-1){1'b1}}};
                1:       bus.in_data[i*IN_W +: IN_W] = {1'b1, {(IN_W-1){1'b0}}};
                default: bus.in_data[i*IN_W +: IN_W] = IN_W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       bus.scale[i*SC_W +: SC_W] = {1'b0, {(SC_W-1){1'b1}}};
                1:       bus.scale[i*SC_W +: SC_W] = {1'b1, {(SC_W-1){1'b0}}};
                default: bus.scale[i*SC_W +: SC_W] = SC_W'($urandom);
            endcase
        end
        bus.shift = SHIFT_W'($urandom_range(0, 31));
        bus.mode  = 1'($urandom_range(0, 1));
    endtask

    // Called just after a falling edge with inputs already driven: samples
    // outputs, advances the model for this cycle's transfers, waits a cycle.
    task automatic applyStimulus();
        #1;
        obsValid   = bus.out_valid;
        obsInReady = bus.in_ready;
        obsData    = bus.out_data;
        obsSat     = bus.sat_flag;
        obsCount   = bus.sat_count;
        inX        = bus.in_valid && bus.in_ready;
        outX       = bus.out_valid && bus.out_ready;
        expCnt     = modelCnt;
        if (outX) begin
            if (expQ.size() > 0) expOut = expQ.pop_front();
            else                 expOut = 'x;
        end
        if (inX) begin
            expQ.push_back(refModel(bus.in_data, bus.scale, int'(bus.shift), bus.mode));
        end
        if (bus.cnt_clr) begin
            modelCnt = 0;
        end else if (outX && (|expOut.sat) && modelCnt != 64'hFFFF_FFFF) begin
            modelCnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.sat_flag !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h sat=%b expected 0/0/0",
                     bus.out_valid, bus.out_data, bus.sat_flag);
        end
        checks++;
        if (bus.sat_count !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_sat_count: got %0d expected 0", bus.sat_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_mode0();
        int aV[CH];
        int bV[CH];
        aV = '{16384, -16384, 1234, -1};
        bV = '{64, 64, -7, 1};
        setLanes(aV, bV);
        bus.shift = '0; bus.mode = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        applyStimulus();
        checks++;
        if (inX !== 1'b1) begin
            errors++; $display("[TB] FAIL mode0_accept: got %b expected 1", inX);
        end
        bus.in_valid = 1'b0;
        applyStimulus();
        checks++;
        if (obsValid !== 1'b0) begin
            errors++; $display("[TB] FAIL mode0_latency_early: got valid=%b expected 0", obsValid);
        end
        applyStimulus();
        checks++;
        if (outX !== 1'b1) begin
            errors++; $display("[TB] FAIL mode0_latency: got valid=%b expected 1", obsValid);
        end
        checks++;
        if (obsData[OUT_W-1:0] !== OUT_W'(4096) || obsSat !== '0) begin
            errors++;
            $display("[TB] FAIL mode0_lane0: got %0d sat=%b expected 4096 sat=0",
                     $signed(obsData[OUT_W-1:0]), obsSat);
        end
        checks++;
        if (obsData !== expOut.data || obsSat !== expOut.sat) begin
            errors++;
            $display("[TB] FAIL mode0_model: got %h/%b expected %h/%b",
                     obsData, obsSat, expOut.data, expOut.sat);
        end
    endtask

    task automatic test_mode1();
        int aT[3][CH];
        int bT[3][CH];
        int sT[3];
        int sent = 0;
        int got = 0;
        longint unsigned startCnt;
        aT = '{'{1000, -1000, 0, 0}, '{7, 32767, -32768, 0}, '{32767, 1, 2, 3}};
        bT = '{'{3, 3, 0, 0}, '{-5, 127, 127, 0}, '{127, 1, 1, 1}};
        sT = '{4, 0, 0};
        startCnt = modelCnt;
        bus.mode = 1'b1; bus.out_ready = 1'b1;
        for (int c = 0; c < 12 && got < 3; c++) begin
            bus.in_valid = (sent < 3);
            if (sent < 3) begin
                setLanes(aT[sent], bT[sent]);
                bus.shift = SHIFT_W'(sT[sent]);
            end
            applyStimulus();
            if (inX) sent++;
            if (outX) begin
                checks++;
                if (obsData !== expOut.data || obsSat !== expOut.sat) begin
                    errors++;
                    $display("[TB] FAIL mode1_model: beat %0d got %h/%b expected %h/%b",
                             got, obsData, obsSat, expOut.data, expOut.sat);
                end
                if (got == 0) begin
                    checks++;
                    if (obsData[OUT_W-1:0] !== OUT_W'(188) ||
                        obsData[2*OUT_W-1:OUT_W] !== OUT_W'(-187) || obsSat[1:0] !== 2'b00) begin
                        errors++;
                        $display("[TB] FAIL mode1_round: got %0d,%0d expected 188,-187",
                                 $signed(obsData[OUT_W-1:0]), $signed(obsData[2*OUT_W-1:OUT_W]));
                    end
                end else if (got == 1) begin
                    checks++;
                    if (obsData[OUT_W-1:0] !== OUT_W'(-35) ||
                        obsData[2*OUT_W-1:OUT_W] !== OUT_W'(32767) ||
                        obsData[3*OUT_W-1:2*OUT_W] !== OUT_W'(-32768) ||
                        obsSat[2:0] !== 3'b110) begin
                        errors++;
                        $display("[TB] FAIL mode1_saturate: got %h sat=%b expected -35,32767,-32768 sat=110",
                                 obsData, obsSat);
                    end
                end
                got++;
            end
        end
        checks++;
        if (got != 3) begin
            errors++; $display("[TB] FAIL mode1_drain: got %0d beats expected 3", got);
        end
        bus.in_valid = 1'b0;
        applyStimulus();
        checks++;
        if (obsCount !== 32'(startCnt + 2)) begin
            errors++;
            $display("[TB] FAIL mode1_sat_count: got %0d expected %0d", obsCount, startCnt + 2);
        end
    endtask

    task automatic test_random();
        int got = 0;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.cnt_clr   = ($urandom_range(0, 31) == 0);
            randomLanes();
            applyStimulus();
            if (outX) begin
                got++;
                checks++;
                if (obsData !== expOut.data || obsSat !== expOut.sat) begin
                    errors++;
                    $display("[TB] FAIL random_beat: cycle %0d got %h/%b expected %h/%b",
                             c, obsData, obsSat, expOut.data, expOut.sat);
                end
            end
            checks++;
            if (obsCount !== expCnt[31:0]) begin
                errors++;
                $display("[TB] FAIL random_sat_count: cycle %0d got %0d expected %0d", c, obsCount, expCnt);
            end
        end
        bus.in_valid = 1'b0; bus.cnt_clr = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
            if (outX) begin
                checks++;
                if (obsData !== expOut.data || obsSat !== expOut.sat) begin
                    errors++;
                    $display("[TB] FAIL random_drain_beat: got %h/%b expected %h/%b",
                             obsData, obsSat, expOut.data, expOut.sat);
                end
            end
        end
        checks++;
        if (expQ.size() != 0 || got == 0) begin
            errors++;
            $display("[TB] FAIL random_drain: got %0d left in flight (%0d seen) expected 0", expQ.size(), got);
        end
    endtask

    task automatic test_backpressure();
        int aV[CH];
        int bV[CH];
        int nextVal = 1;
        int recv = 0;
        int occ;
        bit stalledPrev = 0;
        bit sawFull = 0;
        logic [CH*OUT_W-1:0] held;
        logic expReady;
        bus.mode = 1'b1; bus.shift = '0;
        for (int c = 0; c < 60 && recv < 20; c++) begin
            for (int i = 0; i < CH; i++) begin
                aV[i] = nextVal; bV[i] = 1;
            end
            setLanes(aV, bV);
            bus.in_valid  = (nextVal <= 20);
            bus.out_ready = !(c >= 5 && c <= 9);
            occ = expQ.size();
            applyStimulus();
            expReady = (occ < 2) || bus.out_ready;
            if (occ == 2 && !bus.out_ready) sawFull = 1;
            checks++;
            if (obsInReady !== expReady) begin
                errors++;
                $display("[TB] FAIL bp_in_ready: cycle %0d got %b expected %b", c, obsInReady, expReady);
            end
            if (stalledPrev) begin
                checks++;
                if (obsValid !== 1'b1 || obsData !== held) begin
                    errors++;
                    $display("[TB] FAIL bp_hold: cycle %0d got %b/%h expected 1/%h", c, obsValid, obsData, held);
                end
            end
            stalledPrev = obsValid && !bus.out_ready;
            held        = obsData;
            if (inX) nextVal++;
            if (outX) begin
                recv++;
                checks++;
                if (obsData !== expOut.data || obsData[OUT_W-1:0] !== OUT_W'(recv)) begin
                    errors++;
                    $display("[TB] FAIL bp_order: got %0d expected %0d", $signed(obsData[OUT_W-1:0]), recv);
                end
            end
        end
        checks++;
        if (recv != 20 || !sawFull) begin
            errors++; $display("[TB] FAIL bp_complete: got %0d beats full=%b expected 20 full=1", recv, sawFull);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    endtask

    task automatic test_boundaries();
        int aV[CH];
        int bV[CH];
        int got;
        // Shift of 31 must act as 23: 2^22 rounds up to exactly 1.
        aV = '{-32768, 1000, -7, 32767};
        bV = '{-128, 5, 3, 127};
        setLanes(aV, bV);
        bus.mode = 1'b1; bus.shift = 5'd31; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 6 && got < 1; c++) begin
            applyStimulus();
            bus.in_valid = 1'b0;
            if (outX) begin
                got++;
                checks++;
                if (obsData[OUT_W-1:0] !== OUT_W'(1) || obsData !== expOut.data) begin
                    errors++;
                    $display("[TB] FAIL shift_clamp: got %h expected %h (lane0 1)", obsData, expOut.data);
                end
            end
        end
        // Counter saturation: preload near the top and push saturated beats.
        force dut.satCount_q = 32'hFFFF_FFFE;
        #1;
        release dut.satCount_q;
        modelCnt = 64'hFFFF_FFFE;
        aV = '{32767, 0, 0, 0};
        bV = '{127, 0, 0, 0};
        setLanes(aV, bV);
        bus.shift = '0;
        got = 0;
        for (int c = 0; c < 10 && got < 3; c++) begin
            bus.in_valid = (c < 3);
            applyStimulus();
            if (outX) got++;
        end
        bus.in_valid = 1'b0;
        applyStimulus();
        checks++;
        if (obsCount !== 32'hFFFF_FFFF || expCnt != 64'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL sat_count_max: got %h expected ffffffff", obsCount);
        end
        // Clear coinciding with a saturated transfer: clear wins.
        bus.in_valid = 1'b1;
        got = 0;
        for (int c = 0; c < 8 && got < 1; c++) begin
            bus.cnt_clr = bus.out_valid;
            applyStimulus();
            bus.in_valid = 1'b0;
            if (outX) got++;
        end
        bus.cnt_clr = 1'b0;
        applyStimulus();
        checks++;
        if (got != 1 || obsCount !== 32'd0) begin
            errors++; $display("[TB] FAIL cnt_clr_priority: got %0d expected 0", obsCount);
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.cnt_clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            randomLanes();
            applyStimulus();
        end
        checks++;
        if (obsInReady !== 1'b0 || obsValid !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_full: got ready=%b valid=%b expected 0/1", obsInReady, obsValid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_data !== '0 ||
            bus.sat_flag !== '0 || bus.sat_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_async: got valid=%b ready=%b data=%h cnt=%0d expected all 0",
                     bus.out_valid, bus.in_ready, bus.out_data, bus.sat_count);
        end
        expQ.delete();
        modelCnt = 0;
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            checks++;
            if (obsValid !== 1'b0) begin
                errors++; $display("[TB] FAIL midrst_stale: cycle %0d got valid=1 expected 0", c);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
        bus.in_data = '0; bus.scale = '0; bus.shift = '0; bus.mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_mode0();
        test_mode1();
        test_random();
        test_backpressure();
        test_boundaries();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
